// File: rtl/mem_stage.sv
// Memory-access pipeline stage: runs word load/store transactions on the CPU bus
// and produces the MEM/WB pipeline register plus MEM-stage forwarding data.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] fwd_data,
    input  logic [29:0] ex_pc,
    input  logic        ex_en,
    input  logic        ex_br_flag,
    input  logic [1:0]  ex_mem_op,
    input  logic [31:0] ex_mem_wr_data,
    input  logic [1:0]  ex_ctrl_op,
    input  logic [4:0]  ex_dst_addr,
    input  logic        ex_gpr_we_,
    input  logic [2:0]  ex_exp_code,
    input  logic [31:0] ex_out,
    input  logic [31:0] bus_rd_data,
    input  logic        bus_rdy_,
    input  logic        bus_grnt_,
    output logic        bus_req_,
    output logic [29:0] bus_addr,
    output logic        bus_as_,
    output logic        bus_rw,
    output logic [31:0] bus_wr_data,
    output logic [29:0] mem_pc,
    output logic        mem_en,
    output logic        mem_br_flag,
    output logic [1:0]  mem_ctrl_op,
    output logic [4:0]  mem_dst_addr,
    output logic        mem_gpr_we_,
    output logic [2:0]  mem_exp_code,
    output logic [31:0] mem_out
);

    localparam logic [1:0] MEM_OP_LDW         = 2'd1;
    localparam logic [1:0] MEM_OP_STW         = 2'd2;
    localparam logic [2:0] ISA_EXP_MISS_ALIGN = 3'h4;

    localparam logic [1:0] BUS_IDLE   = 2'd0;
    localparam logic [1:0] BUS_REQ    = 2'd1;
    localparam logic [1:0] BUS_ACCESS = 2'd2;
    localparam logic [1:0] BUS_STALL  = 2'd3;

    logic [1:0]  state_reg, state_next;
    logic [31:0] rd_buf_reg, rd_buf_next;
    logic        first_access_reg, first_access_next;

    logic        is_ldw;
    logic        is_stw;
    logic        mem_access;
    logic        miss_align;
    logic        aligned_access;
    logic [31:0] rd_data;
    logic [31:0] out_next;
    logic [2:0]  exp_code_next;
    logic        gpr_we_next;

    assign is_ldw         = (ex_mem_op == MEM_OP_LDW);
    assign is_stw         = (ex_mem_op == MEM_OP_STW);
    assign mem_access     = ex_en && (is_ldw || is_stw);
    assign miss_align     = mem_access && (ex_out[1:0] != 2'b00);
    assign aligned_access = mem_access && !miss_align;

    // Bus FSM; bus outputs are driven from EX/MEM, which the controller holds while busy.
    always_comb begin
        state_next        = state_reg;
        rd_buf_next       = rd_buf_reg;
        first_access_next = 1'b0;
        rd_data           = '0;
        busy              = 1'b0;
        bus_req_          = 1'b1;
        bus_as_           = 1'b1;
        bus_rw            = 1'b1;
        bus_addr          = '0;
        bus_wr_data       = '0;
        case (state_reg)
            BUS_IDLE: begin
                if (aligned_access && !flush) begin
                    busy       = 1'b1;
                    state_next = BUS_REQ;
                end
            end
            BUS_REQ: begin
                busy        = 1'b1;
                bus_req_    = 1'b0;
                bus_addr    = ex_out[31:2];
                bus_rw      = is_ldw;
                bus_wr_data = ex_mem_wr_data;
                if (flush) begin
                    state_next = BUS_IDLE;
                end else if (!bus_grnt_) begin
                    state_next        = BUS_ACCESS;
                    first_access_next = 1'b1;
                end
            end
            BUS_ACCESS: begin
                bus_req_    = 1'b0;
                bus_as_     = !first_access_reg;
                bus_addr    = ex_out[31:2];
                bus_rw      = is_ldw;
                bus_wr_data = ex_mem_wr_data;
                if (bus_rdy_) begin
                    busy = 1'b1;
                end else begin
                    rd_data     = bus_rd_data;
                    rd_buf_next = bus_rd_data;
                    state_next  = stall ? BUS_STALL : BUS_IDLE;
                end
            end
            default: begin
                rd_data = rd_buf_reg;
                if (!stall) begin
                    state_next = BUS_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        out_next = '0;
        if (ex_en) begin
            if (is_ldw) begin
                out_next = miss_align ? 32'h0 : rd_data;
            end else if (!is_stw) begin
                out_next = ex_out;
            end
        end
    end

    assign fwd_data      = out_next;
    assign exp_code_next = miss_align ? ISA_EXP_MISS_ALIGN : ex_exp_code;
    assign gpr_we_next   = miss_align ? 1'b1 : ex_gpr_we_;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg        <= BUS_IDLE;
            rd_buf_reg       <= '0;
            first_access_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            rd_buf_reg       <= rd_buf_next;
            first_access_reg <= first_access_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_pc       <= '0;
            mem_en       <= 1'b0;
            mem_br_flag  <= 1'b0;
            mem_ctrl_op  <= '0;
            mem_dst_addr <= '0;
            mem_gpr_we_  <= 1'b1;
            mem_exp_code <= '0;
            mem_out      <= '0;
        end else if (stall) begin
            mem_pc       <= mem_pc;
            mem_en       <= mem_en;
            mem_br_flag  <= mem_br_flag;
            mem_ctrl_op  <= mem_ctrl_op;
            mem_dst_addr <= mem_dst_addr;
            mem_gpr_we_  <= mem_gpr_we_;
            mem_exp_code <= mem_exp_code;
            mem_out      <= mem_out;
        end else if (flush) begin
            mem_pc       <= '0;
            mem_en       <= 1'b0;
            mem_br_flag  <= 1'b0;
            mem_ctrl_op  <= '0;
            mem_dst_addr <= '0;
            mem_gpr_we_  <= 1'b1;
            mem_exp_code <= '0;
            mem_out      <= '0;
        end else begin
            mem_pc       <= ex_pc;
            mem_en       <= ex_en;
            mem_br_flag  <= ex_br_flag;
            mem_ctrl_op  <= ex_ctrl_op;
            mem_dst_addr <= ex_dst_addr;
            mem_gpr_we_  <= gpr_we_next;
            mem_exp_code <= exp_code_next;
            mem_out      <= out_next;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a bus responder plus a scoreboard of expected MEM/WB contents.
module tb_mem_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, stall, flush;
    logic        busy;
    logic [31:0] fwd_data;
    logic [29:0] ex_pc;
    logic        ex_en, ex_br_flag;
    logic [1:0]  ex_mem_op, ex_ctrl_op;
    logic [31:0] ex_mem_wr_data, ex_out;
    logic [4:0]  ex_dst_addr;
    logic        ex_gpr_we_;
    logic [2:0]  ex_exp_code;
    logic [31:0] bus_rd_data = 32'hFFFF_FFFF;
    logic        bus_rdy_    = 1'b1;
    logic        bus_grnt_   = 1'b1;
    logic        bus_req_, bus_as_, bus_rw;
    logic [29:0] bus_addr;
    logic [31:0] bus_wr_data;
    logic [29:0] mem_pc;
    logic        mem_en, mem_br_flag, mem_gpr_we_;
    logic [1:0]  mem_ctrl_op;
    logic [4:0]  mem_dst_addr;
    logic [2:0]  mem_exp_code;
    logic [31:0] mem_out;

    mem_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .busy(busy), .fwd_data(fwd_data),
        .ex_pc(ex_pc), .ex_en(ex_en), .ex_br_flag(ex_br_flag), .ex_mem_op(ex_mem_op),
        .ex_mem_wr_data(ex_mem_wr_data), .ex_ctrl_op(ex_ctrl_op), .ex_dst_addr(ex_dst_addr),
        .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code), .ex_out(ex_out),
        .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_), .bus_grnt_(bus_grnt_),
        .bus_req_(bus_req_), .bus_addr(bus_addr), .bus_as_(bus_as_), .bus_rw(bus_rw),
        .bus_wr_data(bus_wr_data), .mem_pc(mem_pc), .mem_en(mem_en), .mem_br_flag(mem_br_flag),
        .mem_ctrl_op(mem_ctrl_op), .mem_dst_addr(mem_dst_addr), .mem_gpr_we_(mem_gpr_we_),
        .mem_exp_code(mem_exp_code), .mem_out(mem_out)
    );

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          grant_delay  = 0;
    int          wait_states  = 0;
    logic [31:0] rsp_data     = 32'h0;
    int          pc_ctr       = 1;

    // Bus slave: grants after grant_delay REQ cycles, then rdy after wait_states ACCESS cycles.
    int   req_cycles = 0;
    int   acc_cycles = 0;
    logic granted    = 1'b0;
    always @(negedge clk) begin
        if (!bus_req_) begin
            if (!granted) begin
                if (req_cycles >= grant_delay) begin
                    bus_grnt_ = 1'b0;
                    granted   = 1'b1;
                end
                req_cycles++;
            end else begin
                if (acc_cycles >= wait_states) begin
                    bus_rdy_    = 1'b0;
                    bus_rd_data = rsp_data;
                end else begin
                    bus_rdy_    = 1'b1;
                    bus_rd_data = 32'hFFFF_FFFF;
                end
                acc_cycles++;
            end
        end else begin
            req_cycles  = 0;
            acc_cycles  = 0;
            granted     = 1'b0;
            bus_grnt_   = 1'b1;
            bus_rdy_    = 1'b1;
            bus_rd_data = 32'hFFFF_FFFF;
        end
    end

    typedef struct {
        string       tag;
        logic [29:0] pc;
        logic        en;
        logic        br;
        logic [1:0]  ctrl;
        logic [4:0]  dst;
        logic        we_;
        logic [2:0]  exc;
        logic [31:0] out;
    } wb_t;
    wb_t sb_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_wb();
        wb_t e;
        e = sb_q.pop_front();
        check({e.tag, ".mem_out"},  mem_out, e.out);
        check({e.tag, ".mem_dst"},  32'(mem_dst_addr), 32'(e.dst));
        check({e.tag, ".mem_exp"},  32'(mem_exp_code), 32'(e.exc));
        check({e.tag, ".mem_we_"},  32'(mem_gpr_we_), 32'(e.we_));
        check({e.tag, ".mem_en"},   32'(mem_en), 32'(e.en));
        check({e.tag, ".mem_pc"},   32'(mem_pc), 32'(e.pc));
        check({e.tag, ".mem_ctl"},  32'({mem_br_flag, mem_ctrl_op}), 32'({e.br, e.ctrl}));
        $display("[TB] %s: mem_out=%h dst=%0d exp=%0d we_=%0d en=%0d",
                 e.tag, mem_out, mem_dst_addr, mem_exp_code, mem_gpr_we_, mem_en);
    endtask

    task automatic push_clear(input string tag);
        wb_t e;
        e.tag = tag; e.pc = '0; e.en = 1'b0; e.br = 1'b0; e.ctrl = '0;
        e.dst = '0; e.we_ = 1'b1; e.exc = '0; e.out = '0;
        sb_q.push_back(e);
    endtask

    function automatic wb_t make_exp(input string tag, input logic [1:0] op, input logic [31:0] alu,
                                     input logic [4:0] dst, input logic we_, input logic [2:0] exc,
                                     input logic [31:0] rdata);
        wb_t  e;
        logic mis;
        mis   = (op == 2'd1 || op == 2'd2) && (alu[1:0] != 2'b00);
        e.tag = tag;
        e.pc  = 30'(pc_ctr * 7 + 3);
        e.en  = 1'b1;
        e.br  = pc_ctr[0];
        e.ctrl = 2'(pc_ctr >> 1);
        e.dst = dst;
        e.we_ = mis ? 1'b1 : we_;
        e.exc = mis ? 3'h4 : exc;
        e.out = mis ? 32'h0 : (op == 2'd1) ? rdata : (op == 2'd2) ? 32'h0 : alu;
        return e;
    endfunction

    task automatic drive_ex(input wb_t e, input logic [1:0] op, input logic [31:0] alu,
                            input logic [31:0] wdata, input logic we_, input logic [2:0] exc);
        ex_en = 1'b1; ex_pc = e.pc; ex_br_flag = e.br; ex_ctrl_op = e.ctrl;
        ex_mem_op = op; ex_out = alu; ex_mem_wr_data = wdata; ex_dst_addr = e.dst;
        ex_gpr_we_ = we_; ex_exp_code = exc;
        pc_ctr++;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] alu,
                          input logic [31:0] wdata, input logic [4:0] dst, input logic we_,
                          input logic [2:0] exc, input int gdel, input int wst, input logic [31:0] rdata);
        wb_t  e;
        logic bus_op;
        int   busy_cyc, as_cyc, req_cyc, cyc;
        bus_op = (op == 2'd1 || op == 2'd2) && (alu[1:0] == 2'b00);
        e = make_exp(tag, op, alu, dst, we_, exc, rdata);
        sb_q.push_back(e);
        grant_delay = gdel; wait_states = wst; rsp_data = rdata;
        @(negedge clk);
        drive_ex(e, op, alu, wdata, we_, exc);
        busy_cyc = 0; as_cyc = 0; req_cyc = 0;
        for (cyc = 0; cyc < 40; cyc++) begin
            #2;
            if (!bus_req_) req_cyc++;
            if (!bus_as_) begin
                as_cyc++;
                check({tag, ".bus_addr"}, 32'(bus_addr), 32'(alu[31:2]));
                check({tag, ".bus_rw"}, 32'(bus_rw), 32'(op == 2'd1));
                check({tag, ".bus_wr_data"}, bus_wr_data, wdata);
            end
            if (!busy) break;
            busy_cyc++;
            @(negedge clk);
        end
        check({tag, ".done_in_time"}, 32'(cyc < 40), 32'd1);
        check({tag, ".fwd_data"}, fwd_data, e.out);
        @(posedge clk); #1;
        check_wb();
        check({tag, ".busy_cycles"}, 32'(busy_cyc), bus_op ? 32'(2 + gdel + wst) : 32'd0);
        check({tag, ".as_cycles"}, 32'(as_cyc), bus_op ? 32'd1 : 32'd0);
        check({tag, ".req_cycles"}, 32'(req_cyc), bus_op ? 32'(gdel + wst + 2) : 32'd0);
        @(negedge clk);
        ex_en = 1'b0; ex_mem_op = 2'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wb_t e;
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        ex_pc = '0; ex_en = 1'b0; ex_br_flag = 1'b0; ex_mem_op = '0; ex_mem_wr_data = '0;
        ex_ctrl_op = '0; ex_dst_addr = '0; ex_gpr_we_ = 1'b1; ex_exp_code = '0; ex_out = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset.mem_gpr_we_", 32'(mem_gpr_we_), 32'd1);
        check("reset.mem_en", 32'(mem_en), 32'd0);
        check("reset.mem_out", mem_out, 32'd0);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.bus_req_", 32'(bus_req_), 32'd1);
        check("reset.bus_as_", 32'(bus_as_), 32'd1);
        check("reset.bus_idle", {1'b0, bus_rw, bus_addr}, 32'h4000_0000);
        $display("[TB] reset: mem_en=%0d mem_gpr_we_=%0d busy=%0d", mem_en, mem_gpr_we_, busy);
        @(negedge clk);
        reset = 1'b1;

        run_op("alu",       2'd0, 32'h1234_5678, 32'h0,         5'd5,  1'b0, 3'h0, 0, 0, 32'h0);
        run_op("ldw_wait2", 2'd1, 32'h0000_0104, 32'h1111_2222, 5'd7,  1'b0, 3'h0, 1, 2, 32'hDEAD_BEEF);
        run_op("stw",       2'd2, 32'h0000_0010, 32'hA5A5_A5A5, 5'd0,  1'b1, 3'h0, 0, 0, 32'h5555_5555);
        run_op("ldw_mis",   2'd1, 32'h0000_0102, 32'h0,         5'd3,  1'b0, 3'h0, 0, 0, 32'h7777_7777);
        run_op("op3_nop",   2'd3, 32'hCAFE_F00D, 32'h0,         5'd12, 1'b0, 3'h2, 0, 0, 32'h0);
        run_op("stw_mis",   2'd2, 32'h0000_0013, 32'h9999_9999, 5'd1,  1'b1, 3'h2, 0, 0, 32'h0);
        run_op("ldw_min",   2'd1, 32'h0000_0008, 32'h0,         5'd31, 1'b0, 3'h0, 0, 0, 32'h1357_9BDF);

        // Stall held across rdy: data parks in rd_buf and lands after stall drops.
        grant_delay = 0; wait_states = 1; rsp_data = 32'h0BAD_F00D;
        e = make_exp("ldw_stall", 2'd1, 32'h0000_0200, 5'd9, 1'b0, 3'h0, 32'h0BAD_F00D);
        sb_q.push_back(e);
        @(negedge clk);
        drive_ex(e, 2'd1, 32'h0000_0200, 32'h0, 1'b0, 3'h0);
        @(negedge clk);
        @(negedge clk);
        stall = 1'b1;
        @(negedge clk);
        #2;
        check("ldw_stall.rdy_busy", 32'(busy), 32'd0);
        check("ldw_stall.rdy_fwd", fwd_data, 32'h0BAD_F00D);
        @(negedge clk);
        #2;
        check("ldw_stall.stall_fwd", fwd_data, 32'h0BAD_F00D);
        check("ldw_stall.stall_busy", 32'(busy), 32'd0);
        check("ldw_stall.stall_req_", 32'(bus_req_), 32'd1);
        check("ldw_stall.held_out", mem_out, 32'h0);
        @(negedge clk);
        stall = 1'b0;
        #2;
        check("ldw_stall.release_fwd", fwd_data, 32'h0BAD_F00D);
        @(posedge clk); #1;
        check_wb();
        @(negedge clk);
        ex_en = 1'b0; ex_mem_op = 2'd0;

        // Flush while waiting for grant.
        grant_delay = 100;
        e = make_exp("flush_req", 2'd1, 32'h0000_0400, 5'd4, 1'b0, 3'h0, 32'h0);
        @(negedge clk);
        drive_ex(e, 2'd1, 32'h0000_0400, 32'h0, 1'b0, 3'h0);
        @(negedge clk);
        flush = 1'b1;
        push_clear("flush_req");
        #2;
        check("flush_req.in_req", 32'(bus_req_), 32'd0);
        @(posedge clk); #1;
        check_wb();
        check("flush_req.req_released", 32'(bus_req_), 32'd1);
        @(negedge clk);
        flush = 1'b0; ex_en = 1'b0; ex_mem_op = 2'd0;
        #2;
        check("flush_req.idle_busy", 32'(busy), 32'd0);

        // Reset while in REQ returns the bus to idle.
        e = make_exp("rst_req", 2'd1, 32'h0000_0300, 5'd6, 1'b0, 3'h0, 32'h0);
        @(negedge clk);
        drive_ex(e, 2'd1, 32'h0000_0300, 32'h0, 1'b0, 3'h0);
        @(negedge clk);
        #2;
        check("rst_req.in_req", 32'(bus_req_), 32'd0);
        reset = 1'b0;
        push_clear("rst_req");
        @(posedge clk); #1;
        check_wb();
        check("rst_req.req_released", 32'(bus_req_), 32'd1);
        @(negedge clk);
        reset = 1'b1; ex_en = 1'b0; ex_mem_op = 2'd0;
        #2;
        check("rst_req.idle_busy", 32'(busy), 32'd0);

        run_op("ldw_after", 2'd1, 32'h0000_0FFC, 32'h0, 5'd10, 1'b0, 3'h0, 2, 1, 32'h2468_ACE0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
